// File: rtl/uart_console_pkg.sv
// Shared register map, line-control constants and FSM state type for the
// Wishbone-to-16550 console master.
package uart_console_pkg;

  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_LSR = 3'd5;

  localparam int unsigned LSR_THRE_BIT = 5;

  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_INIT     = 8'h07;

  localparam logic [2:0] INIT_LAST = 3'd4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POLL,
    ST_WRITE,
    ST_GAP
  } console_state_e;

  // Registers are word-spaced on the bus.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] reg_idx);
    return base + {27'd0, reg_idx, 2'b00};
  endfunction

endpackage

// File: rtl/uart_wb_console_fifo_sync.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_wb_console.sv
// Wishbone classic master that configures a 16550 UART once after reset and
// then streams buffered bytes into THR, polling LSR.THRE before each write.
module uart_wb_console
  import uart_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] DIVISOR    = 16'd27,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic                          init_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [31:0]                   wb_addr_o,
  output logic [31:0]                   wb_data_m_o,
  input  logic [31:0]                   wb_data_s_i,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i,
  input  logic                          wb_stall_i
);

  console_state_e state, state_n;
  logic        cyc, cyc_n, we, we_n;
  logic [31:0] addr, addr_n, data, data_n;
  logic [2:0]  idx, idx_n;
  logic        done, done_n, pend, pend_n;
  logic        launch, push, pop, full, empty;
  logic [7:0]  head;
  logic [2:0]  init_reg;
  logic [7:0]  init_val;

  // Classic mode: stall only prolongs stb, which already holds until ack/err.
  logic unused;
  assign unused = ^{wb_stall_i, wb_data_s_i[31:LSR_THRE_BIT+1], wb_data_s_i[LSR_THRE_BIT-1:0]};

  assign push = in_valid_i && in_ready_o;
  assign in_ready_o = !full;

  fifo_sync #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .push    (push),
    .wr_data (in_data_i),
    .pop     (pop),
    .rd_data (head),
    .count   (fifo_count_o),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    init_reg = REG_FCR;
    init_val = FCR_INIT;
    case (idx)
      3'd0:    begin init_reg = REG_LCR; init_val = LCR_DLAB_8N1;  end
      3'd1:    begin init_reg = REG_DLL; init_val = DIVISOR[7:0];  end
      3'd2:    begin init_reg = REG_DLM; init_val = DIVISOR[15:8]; end
      3'd3:    begin init_reg = REG_LCR; init_val = LCR_8N1;       end
      default: begin init_reg = REG_FCR; init_val = FCR_INIT;      end
    endcase
  end

  // Entering POLL/INIT from GAP/IDLE launches the bus cycle on the transition,
  // so back-to-back transactions are separated by exactly one cyc-low cycle.
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    we_n    = we;
    addr_n  = addr;
    data_n  = data;
    idx_n   = idx;
    done_n  = done;
    pend_n  = pend;
    launch  = 1'b0;
    pop     = 1'b0;
    case (state)
      ST_INIT: begin
        if (!cyc) launch = 1'b1;
        else if (wb_err_i) begin
          cyc_n = 1'b0; state_n = ST_GAP;
        end else if (wb_ack_i) begin
          cyc_n = 1'b0; state_n = ST_GAP;
          if (idx == INIT_LAST) done_n = 1'b1;
          else                  idx_n  = idx + 3'd1;
        end
      end
      ST_IDLE: begin
        if (!empty) begin
          state_n = ST_POLL; pend_n = 1'b1; launch = 1'b1;
        end
      end
      ST_POLL: begin
        if (!cyc) launch = 1'b1;
        else if (wb_err_i) begin
          cyc_n = 1'b0; state_n = ST_GAP;
        end else if (wb_ack_i) begin
          cyc_n = 1'b0;
          if (wb_data_s_i[LSR_THRE_BIT]) begin
            pend_n = 1'b0; state_n = ST_WRITE;
          end else state_n = ST_GAP;
        end
      end
      ST_WRITE: begin
        if (!cyc) launch = 1'b1;
        else if (wb_err_i) begin
          cyc_n = 1'b0; state_n = ST_GAP;
        end else if (wb_ack_i) begin
          cyc_n = 1'b0; pop = 1'b1; state_n = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!done)     begin state_n = ST_INIT; launch = 1'b1; end
        else if (pend) begin state_n = ST_POLL; launch = 1'b1; end
        else           state_n = ST_IDLE;
      end
      default: state_n = ST_INIT;
    endcase
    if (launch) begin
      cyc_n = 1'b1;
      case (state_n)
        ST_INIT: begin
          we_n = 1'b1; addr_n = reg_addr(BASE_ADDR, init_reg); data_n = {24'd0, init_val};
        end
        ST_WRITE: begin
          we_n = 1'b1; addr_n = reg_addr(BASE_ADDR, REG_THR); data_n = {24'd0, head};
        end
        default: begin
          we_n = 1'b0; addr_n = reg_addr(BASE_ADDR, REG_LSR); data_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_INIT;
      cyc   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      data  <= '0;
      idx   <= '0;
      done  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      we    <= we_n;
      addr  <= addr_n;
      data  <= data_n;
      idx   <= idx_n;
      done  <= done_n;
      pend  <= pend_n;
    end
  end

  assign wb_cyc_o    = cyc;
  assign wb_stb_o    = cyc;
  assign wb_we_o     = we;
  assign wb_addr_o   = addr;
  assign wb_data_m_o = data;
  assign init_done_o = done;

endmodule
